// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational AND/OR/NOT ALU between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; an illegal opcode skips EXEC.
module ula_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_z,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic             any_valid;
  logic             grant;
  logic             accept;
  logic             resp_taken;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    sel_a  = grant ? req1_a  : req0_a;
    sel_b  = grant ? req1_b  : req0_b;
    sel_op = grant ? req1_op : req0_op;
  end

  assign accept     = (state_q == IDLE) && any_valid;
  assign resp_taken = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant;
          last_grant_d = grant;
          if (sel_op == OP_ILLEGAL) begin
            // The ALU is bypassed, so its operand registers keep old values.
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
          end else begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        resp_data_d = alu_z;
        resp_err_d  = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (resp_taken) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req0_ready  = accept && !grant;
  assign req1_ready  = accept && grant;
  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) && owner_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_en      = (state_q == EXEC);
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares one combinational ALU (AND/OR/NOT) between two requesters, e.g. the integer datapath and the branch/address unit of the MIPS core.
- Round-robin arbitration with valid/ready request and response handshakes.
- Sequences each operation through a fixed IDLE -> EXEC -> RESP flow.
- Drives the ALU operand/op inputs from registers and captures the ALU result into a response register.

Parameters:
WIDTH, 8, operand/result width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  2  requester 0 opcode: 0 AND, 1 OR, 2 NOT A, 3 illegal
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 takes the result
resp1_valid  output  1  result for requester 1 available
resp1_ready  input  1  requester 1 takes the result
resp_data  output  WIDTH  result, shared by both response channels
resp_err  output  1  result came from an illegal opcode
alu_a  output  WIDTH  operand A to the ALU
alu_b  output  WIDTH  operand B to the ALU
alu_op  output  2  opcode to the ALU
alu_en  output  1  high while the ALU result is being sampled
alu_z  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
busy  output  1  state != IDLE

Behaviour:
- **States:** IDLE, EXEC, RESP.
- **Reset values:** state=IDLE, last_grant=1 (requester 0 wins first tie). All outputs 0, including alu_a/alu_b/alu_op/resp_data/resp_err.
- **Reset mid-operation:** the in-flight transaction is discarded and no response is issued.
- **IDLE, arbitration:**
  - reqN_ready = (state==IDLE) && grant==N, where grant comes from the current valids.
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - Neither valid: both ready=0.
- **IDLE, on handshake (valid&&ready):**
  - Latch a/b/op into alu_a/alu_b/alu_op.
  - Record owner; last_grant<=owner.
  - op!=3: go to EXEC.
  - op==3: go directly to RESP with resp_data=0, resp_err=1; the ALU is not driven, so alu_* keep their prior values and alu_en stays 0.
- **EXEC (exactly 1 cycle):**
  - alu_en=1; alu_a/b/op stable.
  - At the end of the cycle: resp_data<=alu_z, resp_err<=0, go to RESP.
- **RESP:**
  - resp<owner>_valid=1; the other channel's valid=0.
  - resp_data/resp_err are stable until the handshake.
  - On resp<owner>_ready: go to IDLE.
  - The non-owner's resp_ready is ignored.
- **After RESP:** alu_a/b/op and resp_data hold their last values; alu_en=0 outside EXEC.
- **Latency:** a request accepted in cycle t gives resp valid at t+2 (legal op) or t+1 (illegal op). The earliest next accept is the cycle after the response handshake, so the minimum period is 3 cycles per legal op.
- **No queuing:** requests arriving while busy wait; the requester must hold valid and operands stable until ready.
- **Simultaneous events:**
  - A requester whose response is being taken may assert a new request in the same cycle; it is only arbitrated in the following IDLE cycle under the round-robin rule.
  - If both are valid in that IDLE cycle, the other requester wins.
- **Width:** all data paths are WIDTH bits. NOT uses A only; B is latched but ignored by the ALU.

Test Plan:
- **Single request:** after reset, req0 valid a=8'hF0 b=8'h3C op=0 -> req0_ready same cycle, alu_en one cycle later, resp0_valid next cycle with resp_data=8'h30, resp_err=0; resp1_valid stays 0.
- **Round-robin:** req0 and req1 both continuously valid, op=1, a=8'h0F b=8'hF0, resp_ready held 1 -> grants alternate 0,1,0,1; each resp_data=8'hFF; one accept every 3 cycles.
- **Illegal opcode:** req1 op=3 -> resp1_valid one cycle after accept, resp_data=0, resp_err=1, alu_en never asserted.
- **Response backpressure:** req0 op=2 a=8'hA5, resp0_ready held 0 for 5 cycles -> resp0_valid and resp_data=8'h5A held stable; req1 valid meanwhile gets no ready until 1 cycle after resp0 handshake.
- **Reset mid-op:** rst pulsed during EXEC -> next cycle busy=0, no resp_valid. The next simultaneous req0/req1 grants req0.
